// File: rtl/relobi_r_voter_reg.sv
// Registered DMR/TMR majority voter for replicated relOBI R channels, with sticky fault status.
// Optional per-lane saturating mismatch counters are built when RELOBI_VOTER_MIS_CNT_EN is defined.

package obi_pkg;
  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefIdWidth       = 4;
  localparam int unsigned DefOptWidth      = 4;
  localparam int unsigned DefOtherEccWidth = 8;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned OptWidth;
    int unsigned OtherEccWidth;
    bit          UseROptional;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    DataWidth:     DefDataWidth,
    IdWidth:       DefIdWidth,
    OptWidth:      DefOptWidth,
    OtherEccWidth: DefOtherEccWidth,
    UseROptional:  1'b0
  };

  typedef struct packed {
    logic [DefDataWidth-1:0]     rdata;
    logic [DefIdWidth-1:0]       rid;
    logic                        err;
    logic [DefOptWidth-1:0]      r_optional;
    logic [DefOtherEccWidth-1:0] other_ecc;
  } obi_r_chan_t;
endpackage

module relobi_r_voter_reg #(
  parameter obi_pkg::obi_cfg_t ObiCfg       = obi_pkg::ObiDefaultConfig,
  parameter type               obi_r_chan_t = obi_pkg::obi_r_chan_t,
  parameter int unsigned       NumLanes     = 3,
  parameter int unsigned       CntWidth     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  obi_r_chan_t [NumLanes-1:0]         r_i,
  input  logic        [NumLanes-1:0]         rvalid_i,
  output logic                               rready_o,
  output obi_r_chan_t                        r_o,
  output logic                               rvalid_o,
  input  logic                               rready_i,
  input  logic                               clear_i,
  output logic        [NumLanes-1:0]         fault_o,
  output logic                               uncorr_o,
  output logic                               err_pulse_o,
  output logic        [NumLanes-1:0][CntWidth-1:0] mis_cnt_o
);

  obi_r_chan_t [NumLanes-1:0] lane;
  obi_r_chan_t                voted;
  logic                       v_valid;
  logic                       accept;
  logic        [NumLanes-1:0] eq;
  logic        [NumLanes-1:0] mis;
  logic                       uncorr;

  obi_r_chan_t                r_d, r_q;
  logic                       rvalid_d, rvalid_q;
  logic        [NumLanes-1:0] fault_d, fault_q;
  logic                       uncorr_d, uncorr_q;
  logic                       pulse_d, pulse_q;

  // Absent optional fields are zeroed before voting so they can neither leak nor raise faults.
  always_comb begin
    lane = r_i;
    if (!ObiCfg.UseROptional) begin
      for (int unsigned k = 0; k < NumLanes; k++) begin
        lane[k].r_optional = '0;
      end
    end
  end

  assign rready_o = !rvalid_q || rready_i;
  assign accept   = v_valid && rready_o;

  always_comb begin
    eq  = '0;
    mis = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      eq[k]  = (lane[k] == voted);
      mis[k] = (rvalid_i[k] != v_valid) || (accept && rvalid_i[k] && !eq[k]);
    end
  end

  if (NumLanes == 3) begin : g_tmr
    assign voted   = obi_r_chan_t'((lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]));
    assign v_valid = (rvalid_i[0] & rvalid_i[1]) | (rvalid_i[0] & rvalid_i[2]) |
                     (rvalid_i[1] & rvalid_i[2]);
    assign uncorr  = accept && !(|(rvalid_i & eq));
  end else if (NumLanes == 2) begin : g_dmr
    assign voted   = lane[0];
    assign v_valid = rvalid_i[0];
    assign uncorr  = |mis;
  end else begin : g_illegal
    $error("relobi_r_voter_reg: NumLanes must be 2 or 3");
    assign voted   = '0;
    assign v_valid = 1'b0;
    assign uncorr  = 1'b0;
  end

  always_comb begin
    r_d      = r_q;
    rvalid_d = rvalid_q;
    if (accept) begin
      r_d      = voted;
      rvalid_d = 1'b1;
    end else if (rready_i) begin
      rvalid_d = 1'b0;
    end
    // A new event in the clearing cycle still lands in the flags.
    fault_d  = (clear_i ? '0 : fault_q) | mis;
    uncorr_d = (clear_i ? 1'b0 : uncorr_q) | uncorr;
    pulse_d  = |mis;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q      <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= '0;
      uncorr_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      r_q      <= r_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      uncorr_q <= uncorr_d;
      pulse_q  <= pulse_d;
    end
  end

  assign r_o         = r_q;
  assign rvalid_o    = rvalid_q;
  assign fault_o     = fault_q;
  assign uncorr_o    = uncorr_q;
  assign err_pulse_o = pulse_q;

`ifdef RELOBI_VOTER_MIS_CNT_EN
  logic [NumLanes-1:0][CntWidth-1:0] cnt_d, cnt_q;
  logic [CntWidth-1:0]               cnt_base;

  always_comb begin
    cnt_d    = cnt_q;
    cnt_base = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      cnt_base = clear_i ? '0 : cnt_q[k];
      cnt_d[k] = (mis[k] && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mis_cnt_o = cnt_q;
`else
  assign mis_cnt_o = '0;
`endif

endmodule

// File: tb/tb_relobi_r_voter_reg.sv
// Directed bench for relobi_r_voter_reg: a TMR instance and a DMR instance on a shared clock/reset.
module tb_relobi_r_voter_reg;
  typedef obi_pkg::obi_r_chan_t chan_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  chan_t [2:0]       t_r_i;
  logic  [2:0]       t_rvalid_i;
  logic              t_rready_o;
  chan_t             t_r_o;
  logic              t_rvalid_o;
  logic              t_rready_i;
  logic              t_clear_i;
  logic  [2:0]       t_fault_o;
  logic              t_uncorr_o;
  logic              t_pulse_o;
  logic  [2:0][7:0]  t_cnt_o;

  chan_t [1:0]       d_r_i;
  logic  [1:0]       d_rvalid_i;
  logic              d_rready_o;
  chan_t             d_r_o;
  logic              d_rvalid_o;
  logic              d_rready_i;
  logic              d_clear_i;
  logic  [1:0]       d_fault_o;
  logic              d_uncorr_o;
  logic              d_pulse_o;
  logic  [1:0][7:0]  d_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  relobi_r_voter_reg #(.NumLanes(3), .CntWidth(8)) u_tmr (
    .clk_i(clk), .rst_ni(rst_n), .r_i(t_r_i), .rvalid_i(t_rvalid_i), .rready_o(t_rready_o),
    .r_o(t_r_o), .rvalid_o(t_rvalid_o), .rready_i(t_rready_i), .clear_i(t_clear_i),
    .fault_o(t_fault_o), .uncorr_o(t_uncorr_o), .err_pulse_o(t_pulse_o), .mis_cnt_o(t_cnt_o)
  );

  relobi_r_voter_reg #(.NumLanes(2), .CntWidth(8)) u_dmr (
    .clk_i(clk), .rst_ni(rst_n), .r_i(d_r_i), .rvalid_i(d_rvalid_i), .rready_o(d_rready_o),
    .r_o(d_r_o), .rvalid_o(d_rvalid_o), .rready_i(d_rready_i), .clear_i(d_clear_i),
    .fault_o(d_fault_o), .uncorr_o(d_uncorr_o), .err_pulse_o(d_pulse_o), .mis_cnt_o(d_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tmr(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [3:0] id, input logic [2:0] v);
    t_r_i = '0;
    t_r_i[0].rdata = d0;
    t_r_i[1].rdata = d1;
    t_r_i[2].rdata = d2;
    for (int k = 0; k < 3; k++) t_r_i[k].rid = id;
    t_rvalid_i = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t_r_i = '0; t_rvalid_i = '0; t_rready_i = 1'b1; t_clear_i = 1'b0;
    d_r_i = '0; d_rvalid_i = '0; d_rready_i = 1'b1; d_clear_i = 1'b0;
    tick(); tick();
    vectors++; if (t_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b exp 0", t_rvalid_o); end
    vectors++; if (t_r_o !== chan_t'('0)) begin miscompares++; $display("FAIL reset_r got %h exp 0", t_r_o); end
    vectors++; if (t_fault_o !== 3'b000) begin miscompares++; $display("FAIL reset_fault got %b exp 000", t_fault_o); end
    vectors++; if ({t_uncorr_o, t_pulse_o} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b exp 00", {t_uncorr_o, t_pulse_o}); end
    vectors++; if (t_cnt_o !== 24'h0) begin miscompares++; $display("FAIL reset_cnt got %h exp 0", t_cnt_o); end
    vectors++; if (t_rready_o !== 1'b1) begin miscompares++; $display("FAIL reset_rready got %b exp 1", t_rready_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tmr_equal();
    chan_t e;
    drive_tmr(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'd2, 3'b111);
    t_r_i[0].r_optional = 4'hF;
    t_r_i[1].r_optional = 4'hF;
    t_r_i[2].r_optional = 4'h3;
    e = '0; e.rdata = 32'hDEADBEEF; e.rid = 4'd2;
    tick();
    vectors++; if (t_r_o !== e) begin miscompares++; $display("FAIL equal_r got %h exp %h", t_r_o, e); end
    vectors++; if (t_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL equal_rvalid got %b exp 1", t_rvalid_o); end
    vectors++; if (t_fault_o !== 3'b000) begin miscompares++; $display("FAIL equal_fault got %b exp 000", t_fault_o); end
    vectors++; if (t_pulse_o !== 1'b0) begin miscompares++; $display("FAIL equal_pulse got %b exp 0", t_pulse_o); end
    drive_tmr('0, '0, '0, '0, 3'b000);
    tick();
    vectors++; if (t_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL equal_drain got %b exp 0", t_rvalid_o); end
  endtask

  task automatic test_single_flip();
    drive_tmr(32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEF, 4'd1, 3'b111);
    tick();
    vectors++; if (t_r_o.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL flip_rdata got %h exp deadbeef", t_r_o.rdata); end
    vectors++; if (t_fault_o !== 3'b010) begin miscompares++; $display("FAIL flip_fault got %b exp 010", t_fault_o); end
    vectors++; if (t_uncorr_o !== 1'b0) begin miscompares++; $display("FAIL flip_uncorr got %b exp 0", t_uncorr_o); end
    vectors++; if (t_pulse_o !== 1'b1) begin miscompares++; $display("FAIL flip_pulse got %b exp 1", t_pulse_o); end
    drive_tmr('0, '0, '0, '0, 3'b000);
    tick();
    vectors++; if (t_pulse_o !== 1'b0) begin miscompares++; $display("FAIL flip_pulse_fall got %b exp 0", t_pulse_o); end
    vectors++; if (t_fault_o !== 3'b010) begin miscompares++; $display("FAIL flip_sticky got %b exp 010", t_fault_o); end
    t_clear_i = 1'b1;
    tick();
    t_clear_i = 1'b0;
    vectors++; if (t_fault_o !== 3'b000) begin miscompares++; $display("FAIL flip_clear got %b exp 000", t_fault_o); end
  endtask

  task automatic test_uncorr();
    drive_tmr(32'h0, 32'h3, 32'h5, 4'd0, 3'b111);
    tick();
    vectors++; if (t_r_o.rdata !== 32'h1) begin miscompares++; $display("FAIL uncorr_rdata got %h exp 1", t_r_o.rdata); end
    vectors++; if (t_uncorr_o !== 1'b1) begin miscompares++; $display("FAIL uncorr_flag got %b exp 1", t_uncorr_o); end
    vectors++; if (t_fault_o !== 3'b111) begin miscompares++; $display("FAIL uncorr_fault got %b exp 111", t_fault_o); end
    drive_tmr('0, '0, '0, '0, 3'b000);
    t_clear_i = 1'b1;
    tick();
    t_clear_i = 1'b0;
    vectors++; if ({t_uncorr_o, t_fault_o} !== 4'b0000) begin miscompares++; $display("FAIL uncorr_clear got %b exp 0000", {t_uncorr_o, t_fault_o}); end
  endtask

  task automatic test_back_to_back_stall();
    t_rready_i = 1'b0;
    drive_tmr(32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 4'd3, 3'b111);
    tick();
    vectors++; if ({t_rvalid_o, t_r_o.rdata} !== {1'b1, 32'hAAAA0001}) begin miscompares++; $display("FAIL stall_first got %b/%h exp 1/aaaa0001", t_rvalid_o, t_r_o.rdata); end
    drive_tmr(32'hBBBB0002, 32'hBBBB0002, 32'hBBBB0002, 4'd3, 3'b111);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (t_rready_o !== 1'b0) begin miscompares++; $display("FAIL stall_rready[%0d] got %b exp 0", i, t_rready_o); end
      vectors++; if (t_r_o.rdata !== 32'hAAAA0001) begin miscompares++; $display("FAIL stall_hold[%0d] got %h exp aaaa0001", i, t_r_o.rdata); end
      tick();
    end
    t_rready_i = 1'b1;
    #1;
    vectors++; if (t_rready_o !== 1'b1) begin miscompares++; $display("FAIL stall_release got %b exp 1", t_rready_o); end
    tick();
    vectors++; if ({t_rvalid_o, t_r_o.rdata} !== {1'b1, 32'hBBBB0002}) begin miscompares++; $display("FAIL stall_next got %b/%h exp 1/bbbb0002", t_rvalid_o, t_r_o.rdata); end
    drive_tmr('0, '0, '0, '0, 3'b000);
    tick();
    vectors++; if (t_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b exp 0", t_rvalid_o); end
  endtask

  task automatic test_cnt_saturate();
    logic [7:0] exp_sat, exp_one;
`ifdef RELOBI_VOTER_MIS_CNT_EN
    exp_sat = 8'd255; exp_one = 8'd1;
`else
    exp_sat = 8'd0;   exp_one = 8'd0;
`endif
    drive_tmr(32'h1234, 32'h1234, 32'h1234, 4'd0, 3'b001);
    for (int i = 0; i < 300; i++) tick();
    vectors++; if (t_cnt_o[0] !== exp_sat) begin miscompares++; $display("FAIL cnt_sat got %0d exp %0d", t_cnt_o[0], exp_sat); end
    vectors++; if ({t_cnt_o[2], t_cnt_o[1]} !== 16'h0) begin miscompares++; $display("FAIL cnt_others got %h exp 0", {t_cnt_o[2], t_cnt_o[1]}); end
    vectors++; if (t_fault_o !== 3'b001) begin miscompares++; $display("FAIL cnt_fault got %b exp 001", t_fault_o); end
    vectors++; if (t_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL cnt_no_beat got %b exp 0", t_rvalid_o); end
    t_clear_i = 1'b1;
    tick();
    t_clear_i = 1'b0;
    vectors++; if (t_cnt_o[0] !== exp_one) begin miscompares++; $display("FAIL cnt_clear_event got %0d exp %0d", t_cnt_o[0], exp_one); end
    vectors++; if (t_fault_o !== 3'b001) begin miscompares++; $display("FAIL clear_event_fault got %b exp 001", t_fault_o); end
    drive_tmr('0, '0, '0, '0, 3'b000);
    t_clear_i = 1'b1;
    tick();
    t_clear_i = 1'b0;
    vectors++; if ({t_fault_o, t_pulse_o, t_cnt_o[0]} !== 12'h0) begin miscompares++; $display("FAIL cnt_cleared got %h exp 0", {t_fault_o, t_pulse_o, t_cnt_o[0]}); end
  endtask

  task automatic test_reset_mid_stall();
    t_rready_i = 1'b0;
    drive_tmr(32'hC0DE, 32'hC0DE, 32'hC0DE, 4'd5, 3'b111);
    tick();
    drive_tmr(32'hC0DE, 32'hC0DE, 32'hC0DE, 4'd5, 3'b011);
    tick();
    vectors++; if ({t_rvalid_o, t_fault_o, t_pulse_o} !== 5'b1_100_1) begin miscompares++; $display("FAIL pre_reset got %b exp 11001", {t_rvalid_o, t_fault_o, t_pulse_o}); end
    rst_n = 1'b0;
    tick();
    vectors++; if (t_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_rvalid got %b exp 0", t_rvalid_o); end
    vectors++; if (t_r_o !== chan_t'('0)) begin miscompares++; $display("FAIL midrst_r got %h exp 0", t_r_o); end
    vectors++; if ({t_fault_o, t_uncorr_o, t_pulse_o, t_cnt_o} !== 29'h0) begin miscompares++; $display("FAIL midrst_status got %h exp 0", {t_fault_o, t_uncorr_o, t_pulse_o, t_cnt_o}); end
    rst_n = 1'b1;
    t_rready_i = 1'b1;
    drive_tmr('0, '0, '0, '0, 3'b000);
    tick();
  endtask

  task automatic test_dmr();
    d_r_i = '0;
    d_r_i[0].rdata = 32'h1234;
    d_r_i[1].rdata = 32'h1235;
    d_rvalid_i = 2'b11;
    tick();
    vectors++; if (d_r_o.rdata !== 32'h1234) begin miscompares++; $display("FAIL dmr_rdata got %h exp 1234", d_r_o.rdata); end
    vectors++; if (d_uncorr_o !== 1'b1) begin miscompares++; $display("FAIL dmr_uncorr got %b exp 1", d_uncorr_o); end
    vectors++; if ({d_fault_o, d_pulse_o} !== 3'b10_1) begin miscompares++; $display("FAIL dmr_fault got %b exp 101", {d_fault_o, d_pulse_o}); end
    d_r_i[1].rdata = 32'h1234;
    d_rvalid_i = 2'b11;
    tick();
    vectors++; if ({d_rvalid_o, d_pulse_o, d_r_o.rdata} !== {2'b10, 32'h1234}) begin miscompares++; $display("FAIL dmr_agree got %b/%b/%h exp 1/0/1234", d_rvalid_o, d_pulse_o, d_r_o.rdata); end
    d_rvalid_i = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_tmr_equal();
    test_single_flip();
    test_uncorr();
    test_back_to_back_stall();
    test_cnt_saturate();
    test_reset_mid_stall();
    test_dmr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
